// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller: state enum,
// per-state lamp patterns and interval-counter source encodings.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_N_GREEN   = 3'd1,
        ST_N_YELLOW  = 3'd2,
        ST_ALLRED_NE = 3'd3,
        ST_E_GREEN   = 3'd4,
        ST_E_YELLOW  = 3'd5,
        ST_ALLRED_EN = 3'd6,
        ST_EMERG     = 3'd7
    } tc_state_e;

    // One bit per lamp, north group then east group.
    typedef struct packed {
        logic nr;
        logic ng;
        logic ny;
        logic er;
        logic eg;
        logic ey;
    } lamp_t;

    localparam lamp_t LAMP_ALL_RED  = 6'b100_100;
    localparam lamp_t LAMP_N_GREEN  = 6'b010_100;
    localparam lamp_t LAMP_N_YELLOW = 6'b001_100;
    localparam lamp_t LAMP_E_GREEN  = 6'b100_010;
    localparam lamp_t LAMP_E_YELLOW = 6'b100_001;

    localparam logic [1:0] IC_RUN      = 2'b00;
    localparam logic [1:0] IC_FOLLOW_R = 2'b01;
    localparam logic [1:0] IC_NOT_LC   = 2'b10;
    localparam logic [1:0] IC_NOT_LNC  = 2'b11;

    function automatic lamp_t lamp_of(input tc_state_e s);
        case (s)
            ST_N_GREEN:  return LAMP_N_GREEN;
            ST_N_YELLOW: return LAMP_N_YELLOW;
            ST_E_GREEN:  return LAMP_E_GREEN;
            ST_E_YELLOW: return LAMP_E_YELLOW;
            default:     return LAMP_ALL_RED;
        endcase
    endfunction

    function automatic logic [1:0] ic_of(input tc_state_e s);
        case (s)
            ST_N_GREEN:               return IC_NOT_LC;
            ST_E_GREEN:               return IC_NOT_LNC;
            ST_N_YELLOW, ST_E_YELLOW: return IC_RUN;
            default:                  return IC_FOLLOW_R;
        endcase
    endfunction

endpackage

// File: rtl/tc_dwell_counter.sv
// 8-bit saturating dwell counter: clear has priority, then counts up while
// enabled and holds at 255.
module tc_dwell_counter (
    input  logic       clk,
    input  logic       clear,
    input  logic       enable,
    output logic [7:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= 8'd0;
        end else if (enable && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/traffic_controller.sv
// Two-direction traffic light controller with emergency override.
// Optional macro TRAFFIC_CTRL_DWELL_EN gates green exits on MIN_GREEN.
module traffic_controller
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 8,
    parameter int ALLRED    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       not_r,
    input  logic       c_and_l,
    input  logic       en_s,
    input  logic       l_or_notc,
    output logic       s_NR,
    output logic       s_NG,
    output logic       s_NY,
    output logic       s_ER,
    output logic       s_EG,
    output logic       s_EY,
    output logic       en_NR,
    output logic       en_NG,
    output logic       en_NY,
    output logic       en_ER,
    output logic       en_EG,
    output logic       en_EY,
    output logic [1:0] s_IC,
    output logic       en_IC,
    output tc_state_e  state_dbg,
    output logic [7:0] dwell_dbg,
    output logic       min_green_met
);

    localparam logic [7:0] ALLRED_LAST    = 8'(ALLRED - 1);
    localparam logic [7:0] MIN_GREEN_LAST = 8'(MIN_GREEN - 1);

    tc_state_e  state_q;
    tc_state_e  state_d;
    logic [7:0] dwell;
    logic       entry;
    logic       green_ok;
    lamp_t      lamp_q;
    logic       lamp_en_q;
    logic [1:0] s_ic_q;
    logic       en_ic_q;

    // A state visit starts on any transition and on every reset edge.
    assign entry = rst || (state_d != state_q);

    tc_dwell_counter u_dwell (
        .clk    (clk),
        .clear  (entry),
        .enable (1'b1),
        .count  (dwell)
    );

    assign min_green_met = (dwell >= MIN_GREEN_LAST);

`ifdef TRAFFIC_CTRL_DWELL_EN
    assign green_ok = min_green_met;
`else
    assign green_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        if (state_q != ST_EMERG && !not_r) begin
            state_d = ST_EMERG;
        end else begin
            case (state_q)
                ST_INIT:      if (dwell == ALLRED_LAST)   state_d = ST_N_GREEN;
                ST_N_GREEN:   if (c_and_l && green_ok)    state_d = ST_N_YELLOW;
                ST_N_YELLOW:  if (en_s)                   state_d = ST_ALLRED_NE;
                ST_ALLRED_NE: if (dwell == ALLRED_LAST)   state_d = ST_E_GREEN;
                ST_E_GREEN:   if (l_or_notc && green_ok)  state_d = ST_E_YELLOW;
                ST_E_YELLOW:  if (en_s)                   state_d = ST_ALLRED_EN;
                ST_ALLRED_EN: if (dwell == ALLRED_LAST)   state_d = ST_N_GREEN;
                ST_EMERG:     if (not_r)                  state_d = ST_ALLRED_EN;
                default:                                  state_d = ST_INIT;
            endcase
        end
    end

    // Outputs are registered from the next state so they always match the
    // state that is current in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            lamp_q    <= LAMP_ALL_RED;
            lamp_en_q <= 1'b1;
            s_ic_q    <= IC_FOLLOW_R;
            en_ic_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lamp_q    <= lamp_of(state_d);
            lamp_en_q <= (state_d != state_q);
            s_ic_q    <= ic_of(state_d);
            en_ic_q   <= 1'b1;
        end
    end

    assign s_NR = lamp_q.nr;
    assign s_NG = lamp_q.ng;
    assign s_NY = lamp_q.ny;
    assign s_ER = lamp_q.er;
    assign s_EG = lamp_q.eg;
    assign s_EY = lamp_q.ey;

    assign en_NR = lamp_en_q;
    assign en_NG = lamp_en_q;
    assign en_NY = lamp_en_q;
    assign en_ER = lamp_en_q;
    assign en_EG = lamp_en_q;
    assign en_EY = lamp_en_q;

    assign s_IC      = s_ic_q;
    assign en_IC     = en_ic_q;
    assign state_dbg = state_q;
    assign dwell_dbg = dwell;

endmodule

// File: tb/tb_traffic_controller.sv
// Scoreboard bench for traffic_controller: directed scenarios plus random
// status traffic, checked every cycle against a phase/elapsed-time model.
module tb_traffic_controller;
    import traffic_pkg::*;

    localparam int TB_MIN_GREEN = 8;
    localparam int TB_ALLRED    = 2;

    localparam int P_INIT  = 0;
    localparam int P_NG    = 1;
    localparam int P_NY    = 2;
    localparam int P_ARNE  = 3;
    localparam int P_EG    = 4;
    localparam int P_EY    = 5;
    localparam int P_AREN  = 6;
    localparam int P_EMERG = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       not_r = 1'b1;
    logic       c_and_l = 1'b0;
    logic       en_s = 1'b0;
    logic       l_or_notc = 1'b0;
    logic       s_NR, s_NG, s_NY, s_ER, s_EG, s_EY;
    logic       en_NR, en_NG, en_NY, en_ER, en_EG, en_EY;
    logic [1:0] s_IC;
    logic       en_IC;
    tc_state_e  state_dbg;
    logic [7:0] dwell_dbg;
    logic       min_green_met;

    logic [14:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int m_ph     = P_INIT;
    int m_elapsed = 0;

    always #5 clk = ~clk;

    traffic_controller #(
        .MIN_GREEN (TB_MIN_GREEN),
        .ALLRED    (TB_ALLRED)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .not_r         (not_r),
        .c_and_l       (c_and_l),
        .en_s          (en_s),
        .l_or_notc     (l_or_notc),
        .s_NR          (s_NR),
        .s_NG          (s_NG),
        .s_NY          (s_NY),
        .s_ER          (s_ER),
        .s_EG          (s_EG),
        .s_EY          (s_EY),
        .en_NR         (en_NR),
        .en_NG         (en_NG),
        .en_NY         (en_NY),
        .en_ER         (en_ER),
        .en_EG         (en_EG),
        .en_EY         (en_EY),
        .s_IC          (s_IC),
        .en_IC         (en_IC),
        .state_dbg     (state_dbg),
        .dwell_dbg     (dwell_dbg),
        .min_green_met (min_green_met)
    );

    // Expected output word {NR,NG,NY,ER,EG,EY, six enables, s_IC, en_IC}.
    function automatic logic [14:0] expect_vec(input int ph, input bit entered, input bit eic);
        logic [5:0] lamps;
        logic [1:0] ic;
        case (ph)
            P_NG:    begin lamps = 6'b010100; ic = 2'b10; end
            P_NY:    begin lamps = 6'b001100; ic = 2'b00; end
            P_EG:    begin lamps = 6'b100010; ic = 2'b11; end
            P_EY:    begin lamps = 6'b100001; ic = 2'b00; end
            default: begin lamps = 6'b100100; ic = 2'b01; end
        endcase
        return {lamps, {6{entered}}, ic, eic};
    endfunction

    // Cycles already spent in the phase including the current one decide
    // timed exits; green exits need the full minimum green when gated.
    task automatic model_step(input bit r, input bit nr, input bit cl, input bit es, input bit lc);
        int  nxt;
        int  spent;
        bit  green_ok;
        bit  entered;
        spent = m_elapsed + 1;
`ifdef TRAFFIC_CTRL_DWELL_EN
        green_ok = (spent >= TB_MIN_GREEN);
`else
        green_ok = 1'b1;
`endif
        nxt = m_ph;
        if (r) nxt = P_INIT;
        else if (m_ph != P_EMERG && !nr) nxt = P_EMERG;
        else if ((m_ph == P_INIT || m_ph == P_ARNE || m_ph == P_AREN) && spent >= TB_ALLRED)
            nxt = (m_ph == P_ARNE) ? P_EG : P_NG;
        else if (m_ph == P_NG && cl && green_ok) nxt = P_NY;
        else if (m_ph == P_EG && lc && green_ok) nxt = P_EY;
        else if (m_ph == P_NY && es) nxt = P_ARNE;
        else if (m_ph == P_EY && es) nxt = P_AREN;
        else if (m_ph == P_EMERG && nr) nxt = P_AREN;
        entered   = r || (nxt != m_ph);
        m_elapsed = entered ? 0 : ((m_elapsed < 255) ? m_elapsed + 1 : 255);
        m_ph      = nxt;
        exp_q.push_back(expect_vec(nxt, entered, !r));
    endtask

    task automatic step(input bit r, input bit nr, input bit cl, input bit es, input bit lc);
        @(negedge clk);
        rst       = r;
        not_r     = nr;
        c_and_l   = cl;
        en_s      = es;
        l_or_notc = lc;
        model_step(r, nr, cl, es, lc);
    endtask

    task automatic repeat_step(input int n, input bit nr, input bit cl, input bit es, input bit lc);
        for (int i = 0; i < n; i++) step(1'b0, nr, cl, es, lc);
    endtask

    task automatic run_until(input int ph, input bit cl, input bit es, input bit lc);
        int budget;
        budget = 0;
        while (m_ph != ph && budget < 60) begin
            step(1'b0, 1'b1, cl, es, lc);
            budget++;
        end
        n_checks++;
        if (m_ph != ph) begin
            n_fail++;
            $display("FAIL reach_phase: phase %0d not reached within %0d cycles (model at %0d)", ph, budget, m_ph);
        end
    endtask

    always @(posedge clk) begin
        logic [14:0] got;
        logic [14:0] exp;
        #1;
        cycle++;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {s_NR, s_NG, s_NY, s_ER, s_EG, s_EY,
                   en_NR, en_NG, en_NY, en_ER, en_EG, en_EY, s_IC, en_IC};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL outputs at cycle %0d: got %b required %b", cycle, got, exp);
            end
        end
    end

    initial begin
        int emerg_left;
        emerg_left = 0;

        // Reset, then idle so INIT runs its all-red dwell into N_GREEN.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat_step(6, 1'b1, 1'b0, 1'b0, 1'b0);

        // Car waiting raised a few cycles into a fresh N_GREEN.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat_step(2, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat_step(4, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat_step(10, 1'b1, 1'b1, 1'b0, 1'b0);

        // Complete rotation back to N_GREEN.
        repeat_step(2, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat_step(4, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat_step(12, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat_step(5, 1'b1, 1'b0, 1'b0, 1'b0);

        // Emergency raised in E_GREEN together with l_or_notc.
        run_until(P_EG, 1'b1, 1'b1, 1'b0);
        repeat_step(5, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat_step(6, 1'b1, 1'b0, 1'b0, 1'b0);

        // One-cycle reset while in E_YELLOW.
        run_until(P_EY, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat_step(5, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random status traffic with emergency bursts and rare resets.
        for (int i = 0; i < 2000; i++) begin
            bit nr;
            if (emerg_left > 0) begin
                nr = 1'b0;
                emerg_left--;
            end else begin
                nr = 1'b1;
                if ($urandom_range(0, 59) == 0) emerg_left = $urandom_range(1, 6);
            end
            step($urandom_range(0, 199) == 0, nr,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_controller.md
TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

Interface
REQ-001 Parameter MIN_GREEN, default 8: minimum dwell cycles in N_GREEN/E_GREEN; legal range 1..255; used only under TRAFFIC_CTRL_DWELL_EN.
REQ-002 Parameter ALLRED, default 2: dwell cycles in each all-red state; legal range 1..255.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 not_r  in  1  emergency status from datapath; 0 = emergency request.
REQ-006 c_and_l  in  1  car waiting east AND long interval elapsed.
REQ-007 en_s  in  1  short interval elapsed.
REQ-008 l_or_notc  in  1  long interval elapsed OR no car waiting east.
REQ-009 s_NR, s_NG, s_NY, s_ER, s_EG, s_EY  out  1 each  lamp value for the datapath lamp registers.
REQ-010 en_NR, en_NG, en_NY, en_ER, en_EG, en_EY  out  1 each  lamp register load enables.
REQ-011 s_IC  out  2  interval-counter source select: 00 run, 01 follow R, 10 ~(L&C), 11 ~(L|~C).
REQ-012 en_IC  out  1  interval-counter select load enable.

Function
REQ-013 States SHALL be INIT, N_GREEN, N_YELLOW, ALLRED_NE, E_GREEN, E_YELLOW, ALLRED_EN, EMERG.
REQ-014 Lamp pattern (s_* values) SHALL be: INIT/ALLRED_*/EMERG = NR,ER; N_GREEN = NG,ER; N_YELLOW = NY,ER; E_GREEN = NR,EG; E_YELLOW = NR,EY; exactly one lamp per direction is 1.
REQ-015 s_* and s_IC SHALL be registered and SHALL equal the current state's pattern on every cycle.
REQ-016 All six en_* SHALL be 1 only in the first cycle of each state visit and 0 otherwise, so each lamp set is loaded exactly once per visit.
REQ-017 s_IC SHALL be 10 in N_GREEN, 11 in E_GREEN, 00 in both yellows, and 01 in INIT/ALLRED_*/EMERG; en_IC SHALL be 1 in every cycle except while rst is high.
REQ-018 Dwell counter: 8 bits, cleared on state entry, increments each cycle in state, saturates at 255.
REQ-019 INIT -> N_GREEN when dwell count = ALLRED-1.
REQ-020 N_GREEN -> N_YELLOW when c_and_l=1 (and, under TRAFFIC_CTRL_DWELL_EN, dwell >= MIN_GREEN-1).
REQ-021 N_YELLOW -> ALLRED_NE when en_s=1; E_YELLOW -> ALLRED_EN when en_s=1.
REQ-022 ALLRED_NE -> E_GREEN and ALLRED_EN -> N_GREEN when dwell = ALLRED-1.
REQ-023 E_GREEN -> E_YELLOW when l_or_notc=1 (dwell gate as REQ-020).
REQ-024 From any state other than EMERG, not_r=0 -> EMERG, overriding all other transitions in the same cycle.
REQ-025 EMERG holds while not_r=0; on not_r=1 -> ALLRED_EN (then N_GREEN after ALLRED cycles).
REQ-026 Emergency SHALL NOT cause a green-to-red jump without the EMERG all-red pattern being loaded in the following cycle (en_* pulse in EMERG's first cycle).
REQ-027 Transition latency: next state one clk after the qualifying status sample; lamps change in the datapath one further clk later.

Reset
REQ-028 On a clk edge with rst=1: state=INIT, dwell=0, s_NR=s_ER=1, other s_*=0, all en_*=1, s_IC=01, en_IC=0.
REQ-029 rst asserted mid-operation SHALL take effect at the next edge regardless of state or status inputs; first post-reset cycle is INIT with dwell=0.

Configuration
REQ-030 Macro TRAFFIC_CTRL_DWELL_EN defined: green exits additionally gated by MIN_GREEN per REQ-020/023.
REQ-031 Macro undefined: green exits depend only on status inputs; MIN_GREEN is unused; dwell counter still serves INIT/ALLRED_*.

Structure
REQ-032 Shared package traffic_pkg SHALL hold the state enum, the per-state lamp pattern constants and the four s_IC encodings.
REQ-033 Dwell counter SHALL be sub-module tc_dwell_counter (clear, enable, 8-bit saturating count output).

Verification
REQ-034 Reset release, not_r=1, c_and_l=0: INIT 2 cycles, then N_GREEN; en_* high for exactly 1 cycle on entry; s_NG=1, s_ER=1 held.
REQ-035 In N_GREEN, c_and_l=1 at dwell 3, DWELL_EN defined, MIN_GREEN=8: N_YELLOW entered after dwell 7, not before; DWELL_EN undefined: entered next cycle.
REQ-036 Full cycle with en_s pulses and l_or_notc=1: sequence N_GREEN, N_YELLOW, ALLRED_NE(2), E_GREEN, E_YELLOW, ALLRED_EN(2), N_GREEN; s_IC 10,00,01,11,00,01,10.
REQ-037 not_r=0 in E_GREEN concurrent with l_or_notc=1: EMERG next cycle (not E_YELLOW), NR/ER loaded; not_r=1 after 5 cycles -> ALLRED_EN, then N_GREEN.
REQ-038 rst=1 pulsed for one cycle in E_YELLOW: next cycle INIT, outputs per REQ-028, en_IC=0 in that cycle only.
